bcd_stopwatch_ctrl: RTL and testbench
=====================================

BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

Interface
REQ-001: Parameter ROLLOVER, default 1, selects 9999 handling: 1 = wrap to 0000; 0 = saturate at 9999 and stop.
REQ-002: clk  input  1  single clock; all state changes on its rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: tick  input  1  count-enable strobe, one clk cycle wide (nominally 1/100 s).
REQ-005: start_stop  input  1  single-cycle command pulse, toggles run/pause.
REQ-006: lap  input  1  single-cycle command pulse, freezes/unfreezes display.
REQ-007: clear  input  1  single-cycle command pulse, zeroes count and returns to idle.
REQ-008: d3, d2, d1, d0  output  4 each  displayed BCD digits, d3 most significant (range 00.00-99.99).
REQ-009: state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, LAP=11.
REQ-010: running  output  1  high when state is RUN or LAP.
REQ-011: ovf  output  1  sticky overflow flag.

Function
REQ-012: The block SHALL hold an internal 4-digit BCD count (c3..c0) and a 4-digit lap register (l3..l0); all outputs SHALL be registered or decoded from registers only, with no combinational input-to-output path.
REQ-013: Command priority in one cycle SHALL be clear > start_stop > lap; lower-priority commands in that cycle are ignored.
REQ-014: clear in any state SHALL, at the next edge, set state IDLE, count 0000, lap register 0000, ovf 0; a coincident tick is ignored.
REQ-015: IDLE: start_stop -> RUN; lap and tick ignored.
REQ-016: RUN: start_stop -> PAUSE; lap -> LAP, loading the lap register with the count value held before that edge.
REQ-017: LAP: lap -> RUN; start_stop -> PAUSE; in both cases the display returns to the live count.
REQ-018: PAUSE: start_stop -> RUN; lap and tick ignored; count held.
REQ-019: The count SHALL increment by one on every edge where tick=1 and the state before the edge is RUN or LAP; a tick coincident with a start_stop/lap transition still counts if the pre-edge state is RUN or LAP.
REQ-020: Increment SHALL be decimal ripple: c0 9->0 carries to c1, c1 9->0 carries to c2, c2 9->0 carries to c3; each digit takes only values 0-9.
REQ-021: At count 9999 with a counted tick and ROLLOVER=1, the count SHALL become 0000, ovf SHALL set, and the state SHALL be unchanged.
REQ-022: At count 9999 with a counted tick and ROLLOVER=0, the count SHALL stay 9999, ovf SHALL set, and the state SHALL go to PAUSE (overriding lap in that cycle).
REQ-023: ovf SHALL remain set until clear or reset.
REQ-024: d3..d0 SHALL show the lap register when state=LAP, otherwise the live count.
REQ-025: Latency: a counted tick or a command at edge N SHALL be visible on the outputs immediately after edge N.

Reset
REQ-026: rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, count=0000, lap=0000, d3..d0=0000, running=0, ovf=0.
REQ-027: Reset asserted mid-count (RUN or LAP) SHALL discard the count and lap values; after release the block SHALL wait in IDLE for start_stop.
REQ-028: Inputs SHALL be ignored while rst_n=0; the first active edge after release SHALL process inputs normally.

Verification
REQ-029: Reset, start_stop, 12 ticks -> digits 0012, state=01, running=1.
REQ-030: Count 0009 in RUN, one tick -> 0010; from 0099 -> 0100; from 0999 -> 1000.
REQ-031: In RUN at 0025, lap; 5 more ticks -> display 0025, state=11; lap again -> display 0030, state=01.
REQ-032: In RUN at 0040, start_stop; 3 ticks -> 0040, state=10; start_stop, 1 tick -> 0041.
REQ-033: Count 9999 in RUN, one tick -> ROLLOVER=1: 0000, ovf=1, state=01; ROLLOVER=0: 9999, ovf=1, state=10.
REQ-034: clear+start_stop+tick in the same cycle while RUN at 0123 -> 0000, state=00, ovf=0; rst_n pulsed low between clk edges while RUN -> outputs zero immediately.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl.sv
// Four-digit BCD stopwatch (00.00-99.99) with run/pause/lap control.
// ROLLOVER selects wrap-to-zero or saturate-and-pause at 9999.
module bcd_stopwatch_ctrl #(
  parameter bit ROLLOVER = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [1:0] state,
  output logic       running,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [3:0][3:0] cnt_q, cnt_d;
  logic [3:0][3:0] lap_q, lap_d;
  logic            ovf_q, ovf_d;

  logic [3:0][3:0] cnt_inc;
  logic            carry;
  logic            counting;
  logic            at_max;

  // Decimal ripple increment of the live count.
  always_comb begin
    cnt_inc = cnt_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cnt_q[i] == 4'd9) begin
          cnt_inc[i] = 4'd0;
        end else begin
          cnt_inc[i] = cnt_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
  end

  assign counting = tick && ((state_q == RUN) || (state_q == LAP));
  assign at_max   = (cnt_q == 16'h9999);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;
    ovf_d   = ovf_q;

    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      lap_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_stop) state_d = RUN;
        end
        RUN: begin
          if (start_stop) begin
            state_d = PAUSE;
          end else if (lap) begin
            state_d = LAP;
            lap_d   = cnt_q;
          end
        end
        LAP: begin
          if (start_stop)  state_d = PAUSE;
          else if (lap)    state_d = RUN;
        end
        PAUSE: begin
          if (start_stop) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase

      // Saturation forces PAUSE regardless of any command taken above.
      if (counting) begin
        if (at_max) begin
          ovf_d = 1'b1;
          if (ROLLOVER) begin
            cnt_d = '0;
          end else begin
            state_d = PAUSE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign {d3, d2, d1, d0} = (state_q == LAP) ? lap_q : cnt_q;
  assign state            = state_q;
  assign running          = (state_q == RUN) || (state_q == LAP);
  assign ovf              = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench driving a wrapping and a saturating stopwatch in lockstep.
module tb_bcd_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic start_stop = 1'b0;
  logic lap = 1'b0;
  logic clear = 1'b0;

  logic [3:0] w_d3, w_d2, w_d1, w_d0, s_d3, s_d2, s_d1, s_d0;
  logic [1:0] w_state, s_state;
  logic       w_running, s_running, w_ovf, s_ovf;

  typedef struct packed {
    logic        inst;
    logic [15:0] digits;
    logic [1:0]  st;
    logic        run;
    logic        ov;
    logic [15:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   next_id = 0;
  event check_ev;

  always #5 clk = ~clk;

  bcd_stopwatch_ctrl #(.ROLLOVER(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop),
    .lap(lap), .clear(clear),
    .d3(w_d3), .d2(w_d2), .d1(w_d1), .d0(w_d0),
    .state(w_state), .running(w_running), .ovf(w_ovf)
  );

  bcd_stopwatch_ctrl #(.ROLLOVER(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop),
    .lap(lap), .clear(clear),
    .d3(s_d3), .d2(s_d2), .d1(s_d1), .d0(s_d0),
    .state(s_state), .running(s_running), .ovf(s_ovf)
  );

  // Drive one clock cycle of commands, releasing them just after the edge.
  task automatic applyStimulus(input logic ss, input logic lp,
                               input logic clr, input logic tk);
    start_stop = ss;
    lap        = lp;
    clear      = clr;
    tick       = tk;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
    tick       = 1'b0;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic checkOutput(input logic inst, input logic [15:0] digits,
                             input logic [1:0] st, input logic run,
                             input logic ov);
    exp_t e;
    e.inst   = inst;
    e.digits = digits;
    e.st     = st;
    e.run    = run;
    e.ov     = ov;
    e.id     = 16'(next_id);
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic checkBoth(input logic [15:0] digits, input logic [1:0] st,
                           input logic run, input logic ov);
    checkOutput(1'b0, digits, st, run, ov);
    checkOutput(1'b1, digits, st, run, ov);
  endtask

  // Pull reset low between clock edges and check outputs before any edge.
  task automatic asyncResetCheck();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkBoth(16'h0000, 2'b00, 1'b0, 1'b0);
    ->check_ev;
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares every queued expectation against the selected DUT.
  initial begin
    exp_t        e;
    logic [20:0] act;
    forever begin
      @(negedge clk or check_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.inst)
          act = {s_d3, s_d2, s_d1, s_d0, s_state, s_running, s_ovf};
        else
          act = {w_d3, w_d2, w_d1, w_d0, w_state, w_running, w_ovf};
        checks++;
        if (act != {e.digits, e.st, e.run, e.ov}) begin
          errors++;
          $display("[TB] FAIL check%0d %s: got digits=%h state=%b running=%b ovf=%b, expected digits=%h state=%b running=%b ovf=%b",
                   e.id, e.inst ? "sat" : "wrap", act[20:5], act[4:3], act[2], act[1],
                   e.digits, e.st, e.run, e.ov);
        end
      end
    end
  end

  initial begin
    #3;
    checkBoth(16'h0000, 2'b00, 1'b0, 1'b0);
    ->check_ev;
    #4;
    rst_n = 1'b1;

    // IDLE ignores tick and lap, start_stop enters RUN.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0); checkBoth(16'h0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); checkBoth(16'h0000, 2'b01, 1'b1, 1'b0);
    runTicks(11);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h0012, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); checkBoth(16'h0000, 2'b00, 1'b0, 1'b0);

    // Decimal carries.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(8);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h0009, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h0010, 2'b01, 1'b1, 1'b0);
    runTicks(88);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h0099, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h0100, 2'b01, 1'b1, 1'b0);
    runTicks(898);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h0999, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h1000, 2'b01, 1'b1, 1'b0);

    // Lap freeze and release, including a tick on the lap edge.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(24);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h0025, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0); checkBoth(16'h0025, 2'b11, 1'b1, 1'b0);
    runTicks(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h0025, 2'b11, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0); checkBoth(16'h0030, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1); checkBoth(16'h0030, 2'b11, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); checkBoth(16'h0031, 2'b10, 1'b0, 1'b0);

    // Pause holds the count.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(40);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); checkBoth(16'h0040, 2'b10, 1'b0, 1'b0);
    runTicks(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1); checkBoth(16'h0040, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); checkBoth(16'h0040, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h0041, 2'b01, 1'b1, 1'b0);

    // Command priority.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0); checkBoth(16'h0000, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0); checkBoth(16'h0000, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(123);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1); checkBoth(16'h0000, 2'b00, 1'b0, 1'b0);

    // Plain 9999 boundary.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(9998);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h9999, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(1'b0, 16'h0000, 2'b01, 1'b1, 1'b1);
    checkOutput(1'b1, 16'h9999, 2'b10, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(1'b0, 16'h0001, 2'b01, 1'b1, 1'b1);
    checkOutput(1'b1, 16'h9999, 2'b10, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); checkBoth(16'h0000, 2'b00, 1'b0, 1'b0);

    // 9999 boundary with a coincident lap.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(9999);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput(1'b0, 16'h9999, 2'b11, 1'b1, 1'b1);
    checkOutput(1'b1, 16'h9999, 2'b10, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(1'b0, 16'h9999, 2'b11, 1'b1, 1'b1);
    checkOutput(1'b1, 16'h9999, 2'b10, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(1'b0, 16'h0001, 2'b01, 1'b1, 1'b1);
    checkOutput(1'b1, 16'h9999, 2'b10, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(1'b0, 16'h0001, 2'b10, 1'b0, 1'b1);
    checkOutput(1'b1, 16'h9999, 2'b01, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(1'b0, 16'h0001, 2'b10, 1'b0, 1'b1);
    checkOutput(1'b1, 16'h9999, 2'b10, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0); checkBoth(16'h0000, 2'b00, 1'b0, 1'b0);

    // Asynchronous reset mid-count, then wait in IDLE.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h0005, 2'b01, 1'b1, 1'b0);
    asyncResetCheck();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); checkBoth(16'h0000, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1); checkBoth(16'h0001, 2'b01, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
